verif_disparo: RTL and testbench
================================

Name: verif_disparo

Overview:
Shot-resolution stage of the battleship game, directly downstream of the main game FSM.
- Receives one shot coordinate per turn from the player or PC turn logic.
- Looks the coordinate up in the registered ship map and records the result in the hit and shot maps.
- Reports hit, miss, repeat or invalid.
- Drives all_sunk (the FSM's `lp` input) once no ship cells remain.

Parameters:
- ROWS, 5, board rows
- COLS, 5, board columns
- CELLS, ROWS*COLS (25), number of board cells (derived)
- CW, $clog2(CELLS+1) (5), width of cells_left

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle pulse; latch ship_map and start a new board
- ship_map  in  CELLS  occupancy map from ship registration; bit index = row*COLS+col
- shot_valid  in  1  shot request
- shot_row  in  3  shot row
- shot_col  in  3  shot column
- shot_ready  out  1  stage can accept a shot
- res_valid  out  1  one-cycle result strobe
- res_hit  out  1  shot hit a previously unshot ship cell
- res_repeat  out  1  cell had already been shot
- res_invalid  out  1  coordinate off the board
- cells_left  out  CW  ship cells not yet hit
- hit_map  out  CELLS  cells hit so far
- shot_map  out  CELLS  cells shot so far (hits and misses)
- all_sunk  out  1  every ship cell hit; game over

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous and active-high.
- Reset values: state=IDLE; hit_map=0; shot_map=0; cells_left=0; all_sunk=0; res_*=0; shot_ready=0.
  - After reset the stage stays in IDLE with shot_ready=0 until the first load. No board is loaded until then.
- States: IDLE, LOOKUP, UPDATE, REPORT, OVER.
- load: takes priority in every state.
  - Clears hit_map and shot_map.
  - Sets cells_left = popcount(ship_map).
  - Aborts any in-flight shot with no res_valid.
  - Next state is IDLE, or OVER if the popcount is 0.
- shot_ready = (state==IDLE) && board loaded && !load.
- Accept: shot_valid && shot_ready at edge k.
  - Coordinates are registered at that edge; state goes to LOOKUP.
- LOOKUP:
  - idx = shot_row*COLS+shot_col, computed 5 bits wide.
  - Registers inv = (row>=ROWS || col>=COLS), occ = ship_map[idx], rep = shot_map[idx].
  - When inv=1, occ and rep are forced to 0.
  - Next state: UPDATE.
- UPDATE: priority is invalid > repeat > hit/miss.
  - Invalid or repeat: no map change, no counter change.
  - Otherwise: shot_map[idx] set.
  - If occ: hit_map[idx] set and cells_left decremented. The decrement never goes below 0.
  - Next state: REPORT.
- REPORT:
  - res_valid=1 for exactly one cycle, with res_hit/res_repeat/res_invalid one-hot or all 0 (all 0 = miss).
  - res_valid is high in the cycle after edge k+3.
  - Next state: OVER if cells_left==0, else IDLE.
  - all_sunk asserts in the same cycle as the res_valid of the sinking shot.
- Result flags hold their value until the next REPORT and are cleared on load. Only res_valid is a strobe.
- OVER: shot_ready=0; all_sunk=1; shot_valid is ignored. The state is left only by load or rst.
- Upstream handshake: shot_valid/row/col must remain stable until accepted. Requests are not queued.
- ship_map is sampled on load only. Later changes to the input have no effect.
- Throughput: one shot per 4 cycles.

Decomposition:
- Package battleship_pkg holds:
  - ROWS and COLS constants
  - the state_t enum of this block
  - the shot result code enum (MISS, HIT, REPEAT, INVALID), shared with the main game FSM
- Sub-module cell_count: combinational popcount of CELLS bits, CW-bit output, used on load.

Test Plan:
1. Reset and load: rst; load with ship_map=25'h0000007 -> cells_left=3, shot_ready=1, hit_map=0, all_sunk=0.
2. Hit then miss: shot (0,1) -> res_valid 4 cycles after the accept edge, res_hit=1, cells_left=2, hit_map bit1 set. Shot (4,4) -> miss, shot_map bit24 set, cells_left stays 2.
3. Repeat and invalid:
   - Shot (0,1) again -> res_repeat=1, cells_left stays 2.
   - Shot (5,0) -> res_invalid=1, maps unchanged.
   - Shot (7,7) -> res_invalid=1, with no false index-alias hit.
4. Game over: shots (0,0) then (0,2) -> the second report has res_hit=1 and all_sunk=1 in the res_valid cycle. Afterwards shot_ready=0 and a further shot_valid produces no res_valid.
5. Abort and priority:
   - Load 25'h1000000, accept (4,4), assert load during LOOKUP -> no res_valid, maps cleared, cells_left=1.
   - load and shot_valid in the same IDLE cycle -> shot not accepted.
6. Empty board and mid-shot reset:
   - load with ship_map=0 -> cells_left=0, all_sunk=1, shot_ready=0.
   - rst asserted during UPDATE -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/battleship_pkg.sv
// Types shared by the battleship game stages: board size, shot-resolution
// FSM states and the shot result code seen by the main game FSM.
package battleship_pkg;

  localparam int ROWS = 5;
  localparam int COLS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_REPORT,
    ST_OVER
  } state_t;

  typedef enum logic [1:0] {
    RES_MISS,
    RES_HIT,
    RES_REPEAT,
    RES_INVALID
  } shot_res_t;

endpackage

// File: rtl/cell_count.sv
// Combinational population count of an N-bit occupancy map.
module cell_count #(
  parameter int N = 25,
  parameter int W = 5
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/verif_disparo.sv
// Shot-resolution stage: looks a shot up in the latched ship map, updates
// the hit/shot maps and remaining-cell count, and reports the result.
module verif_disparo #(
  parameter  int ROWS  = battleship_pkg::ROWS,
  parameter  int COLS  = battleship_pkg::COLS,
  localparam int CELLS = ROWS * COLS,
  localparam int CW    = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CELLS-1:0] ship_map,
  input  logic             shot_valid,
  input  logic [2:0]       shot_row,
  input  logic [2:0]       shot_col,
  output logic             shot_ready,
  output logic             res_valid,
  output logic             res_hit,
  output logic             res_repeat,
  output logic             res_invalid,
  output logic [CW-1:0]    cells_left,
  output logic [CELLS-1:0] hit_map,
  output logic [CELLS-1:0] shot_map,
  output logic             all_sunk
);

  import battleship_pkg::*;

  state_t           state_q;
  shot_res_t        code_q;
  logic [CELLS-1:0] ship_q, hit_q, shot_q;
  logic [CW-1:0]    cells_q;
  logic [2:0]       row_q, col_q;
  logic [4:0]       idx_q;
  logic             inv_q, occ_q, rep_q;
  logic             loaded_q, all_sunk_q;
  logic             res_valid_q, res_hit_q, res_rep_q, res_inv_q;

  logic [CW-1:0]    load_count_d;
  logic [4:0]       idx_d;
  logic             inv_d;

  cell_count #(.N(CELLS), .W(CW)) u_cell_count (
    .bits_i  (ship_map),
    .count_o (load_count_d)
  );

  // Index is deliberately 5 bits; off-board coordinates may alias, so the
  // lookup results are masked by inv_d below.
  assign idx_d = 5'(row_q) * 5'(COLS) + 5'(col_q);
  assign inv_d = (32'(row_q) >= ROWS) || (32'(col_q) >= COLS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= RES_MISS;
      ship_q      <= '0;
      hit_q       <= '0;
      shot_q      <= '0;
      cells_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      inv_q       <= 1'b0;
      occ_q       <= 1'b0;
      rep_q       <= 1'b0;
      loaded_q    <= 1'b0;
      all_sunk_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_rep_q   <= 1'b0;
      res_inv_q   <= 1'b0;
    end else if (load) begin
      // A new board wins over anything in flight.
      ship_q      <= ship_map;
      hit_q       <= '0;
      shot_q      <= '0;
      cells_q     <= load_count_d;
      loaded_q    <= 1'b1;
      all_sunk_q  <= (load_count_d == '0);
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_rep_q   <= 1'b0;
      res_inv_q   <= 1'b0;
      state_q     <= (load_count_d == '0) ? ST_OVER : ST_IDLE;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (shot_valid && loaded_q) begin
            row_q   <= shot_row;
            col_q   <= shot_col;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          idx_q   <= idx_d;
          inv_q   <= inv_d;
          occ_q   <= !inv_d && ship_q[idx_d];
          rep_q   <= !inv_d && shot_q[idx_d];
          state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (inv_q) begin
            code_q <= RES_INVALID;
          end else if (rep_q) begin
            code_q <= RES_REPEAT;
          end else begin
            shot_q[idx_q] <= 1'b1;
            if (occ_q) begin
              hit_q[idx_q] <= 1'b1;
              if (cells_q != '0) cells_q <= cells_q - CW'(1);
              code_q <= RES_HIT;
            end else begin
              code_q <= RES_MISS;
            end
          end
          state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          res_valid_q <= 1'b1;
          res_hit_q   <= (code_q == RES_HIT);
          res_rep_q   <= (code_q == RES_REPEAT);
          res_inv_q   <= (code_q == RES_INVALID);
          all_sunk_q  <= (cells_q == '0);
          state_q     <= (cells_q == '0) ? ST_OVER : ST_IDLE;
        end
        ST_OVER: state_q <= ST_OVER;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shot_ready  = (state_q == ST_IDLE) && loaded_q && !load;
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign res_repeat  = res_rep_q;
  assign res_invalid = res_inv_q;
  assign cells_left  = cells_q;
  assign hit_map     = hit_q;
  assign shot_map    = shot_q;
  assign all_sunk    = all_sunk_q;

endmodule

// File: tb/tb_verif_disparo.sv
// Bench for verif_disparo: directed game scenarios plus random shots, all
// compared every cycle against a transaction-level board model.
module tb_verif_disparo;

  logic        clk = 1'b0;
  logic        rst, load, shot_valid;
  logic [24:0] ship_map;
  logic [2:0]  shot_row, shot_col;
  logic        shot_ready, res_valid, res_hit, res_repeat, res_invalid, all_sunk;
  logic [4:0]  cells_left;
  logic [24:0] hit_map, shot_map;

  verif_disparo dut (
    .clk(clk), .rst(rst), .load(load), .ship_map(ship_map),
    .shot_valid(shot_valid), .shot_row(shot_row), .shot_col(shot_col),
    .shot_ready(shot_ready), .res_valid(res_valid), .res_hit(res_hit),
    .res_repeat(res_repeat), .res_invalid(res_invalid), .cells_left(cells_left),
    .hit_map(hit_map), .shot_map(shot_map), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input bit [24:0] v);
    int n = 0;
    for (int i = 0; i < 25; i++) n += v[i];
    return n;
  endfunction

  // Board model: a shot's outcome is decided when it is accepted and becomes
  // visible on the outputs together with its result strobe three edges later.
  bit [24:0] m_ship, m_hit, m_shot, p_hit, p_shot;
  int        m_cells, p_cells, m_due, cyc = 0;
  bit        m_loaded, m_over, m_busy, m_sunk, m_rv;
  bit        m_fh, m_fr, m_fi, p_fh, p_fr, p_fi;

  always @(posedge clk) begin
    m_rv = 1'b0;
    if (rst) begin
      m_ship = '0; m_hit = '0; m_shot = '0; m_cells = 0;
      m_loaded = 0; m_over = 0; m_busy = 0; m_sunk = 0;
      m_fh = 0; m_fr = 0; m_fi = 0;
    end else if (load) begin
      m_ship = ship_map; m_hit = '0; m_shot = '0;
      m_cells = popc(ship_map);
      m_over = (m_cells == 0); m_sunk = m_over;
      m_fh = 0; m_fr = 0; m_fi = 0;
      m_busy = 0; m_loaded = 1;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        m_fh = p_fh; m_fr = p_fr; m_fi = p_fi;
        m_hit = p_hit; m_shot = p_shot; m_cells = p_cells;
        m_rv = 1'b1; m_busy = 0;
        if (m_cells == 0) begin m_over = 1; m_sunk = 1; end
      end
    end else if (shot_valid && m_loaded && !m_over) begin
      int r, c, idx;
      r = int'(shot_row); c = int'(shot_col);
      p_hit = m_hit; p_shot = m_shot; p_cells = m_cells;
      p_fh = 0; p_fr = 0; p_fi = 0;
      if (r >= 5 || c >= 5) p_fi = 1;
      else begin
        idx = r * 5 + c;
        if (m_shot[idx]) p_fr = 1;
        else begin
          p_shot[idx] = 1'b1;
          if (m_ship[idx]) begin
            p_hit[idx] = 1'b1; p_fh = 1;
            if (p_cells > 0) p_cells--;
          end
        end
      end
      m_busy = 1; m_due = cyc + 3;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("shot_ready", shot_ready, m_loaded && !m_over && !m_busy && !load);
      chk("res_valid", res_valid, m_rv);
      chk("res_hit", res_hit, m_fh);
      chk("res_repeat", res_repeat, m_fr);
      chk("res_invalid", res_invalid, m_fi);
      chk("all_sunk", all_sunk, m_sunk);
      if (!m_busy) begin
        chk("cells_left", cells_left, m_cells);
        chk("hit_map", hit_map, m_hit);
        chk("shot_map", shot_map, m_shot);
      end
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  logic        c_hit, c_rep, c_inv, c_sunk;
  logic [4:0]  c_cells;
  logic [24:0] c_hmap, c_smap;
  int          lat;

  task automatic do_load(input logic [24:0] map);
    ship_map = map; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic shot(input int r, input int c);
    bit ok = 0;
    bit rdy;
    shot_row = 3'(r); shot_col = 3'(c); shot_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); rdy = shot_ready;
      @(posedge clk); #1;
      ok = rdy;
    end
    shot_valid = 1'b0;
    chk("accept_timeout", ok, 1);
    lat = 0;
    for (int i = 1; i <= 8 && ok; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        c_hit = res_hit; c_rep = res_repeat; c_inv = res_invalid; c_sunk = all_sunk;
        c_cells = cells_left; c_hmap = hit_map; c_smap = shot_map;
        break;
      end
    end
    if (ok) begin
      chk("latency", lat, 4);
      @(posedge clk); #1;
    end
  endtask

  function automatic int count_rv_start();
    return 0;
  endfunction

  task automatic watch_no_result(input string name, input int ncyc);
    int n = count_rv_start();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk); if (res_valid) n++;
    end
    chk(name, n, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; shot_valid = 1'b0; ship_map = '0;
    shot_row = '0; shot_col = '0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", shot_ready, 0); chk("rst_cells", cells_left, 0);
    chk("rst_sunk", all_sunk, 0); chk("rst_hmap", hit_map, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Load and first shots
    do_load(25'h0000007);
    @(negedge clk);
    chk("load_cells", cells_left, 3); chk("load_ready", shot_ready, 1);
    chk("load_hmap", hit_map, 0); chk("load_sunk", all_sunk, 0);
    @(posedge clk); #1;
    shot(0, 1);
    chk("hit_flag", c_hit, 1); chk("hit_cells", c_cells, 2); chk("hit_hmap", c_hmap, 25'h2);
    shot(4, 4);
    chk("miss_flag", {c_hit, c_rep, c_inv}, 0); chk("miss_smap", c_smap, 25'h1000002);
    chk("miss_cells", c_cells, 2);

    // Repeat and invalid
    shot(0, 1);
    chk("rep_flag", c_rep, 1); chk("rep_cells", c_cells, 2);
    shot(5, 0);
    chk("inv_flag", c_inv, 1); chk("inv_smap", c_smap, 25'h1000002);
    shot(7, 7);
    chk("inv77_flag", {c_hit, c_rep, c_inv}, 3'b001); chk("inv77_hmap", c_hmap, 25'h2);

    // Sinking the last ship cell
    shot(0, 0);
    chk("sink1_cells", c_cells, 1);
    shot(0, 2);
    chk("sink_hit", c_hit, 1); chk("sink_sunk", c_sunk, 1); chk("sink_cells", c_cells, 0);
    shot_row = 3'd3; shot_col = 3'd3; shot_valid = 1'b1;
    watch_no_result("over_no_result", 8);
    shot_valid = 1'b0;

    // Load aborts a shot in LOOKUP
    do_load(25'h1000000);
    shot_row = 3'd4; shot_col = 3'd4; shot_valid = 1'b1;
    @(posedge clk); #1 shot_valid = 1'b0; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    watch_no_result("abort_no_result", 6);
    chk("abort_cells", cells_left, 1); chk("abort_hmap", hit_map, 0); chk("abort_smap", shot_map, 0);

    // Load and shot in the same cycle: shot is not taken
    load = 1'b1; shot_valid = 1'b1;
    @(negedge clk); chk("load_blocks_ready", shot_ready, 0);
    @(posedge clk); #1 load = 1'b0; shot_valid = 1'b0;
    watch_no_result("load_shot_no_result", 6);
    chk("load_shot_smap", shot_map, 0);

    // Empty board
    do_load(25'h0);
    @(negedge clk);
    chk("empty_cells", cells_left, 0); chk("empty_sunk", all_sunk, 1); chk("empty_ready", shot_ready, 0);
    @(posedge clk); #1;

    // Reset while the shot is in UPDATE
    do_load(25'h1000000);
    shot_row = 3'd4; shot_col = 3'd4; shot_valid = 1'b1;
    @(posedge clk); #1 shot_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rv", res_valid, 0); chk("mid_rst_cells", cells_left, 0);
    chk("mid_rst_sunk", all_sunk, 0); chk("mid_rst_ready", shot_ready, 0);
    chk("mid_rst_maps", {hit_map, shot_map}, 0); chk("mid_rst_hit", res_hit, 0);
    @(posedge clk); #1;

    // Random play
    for (int t = 0; t < 400; t++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (!m_loaded || m_over || pick < 3) begin
        if ($urandom_range(0, 3) == 0) do_load(25'(1) << $urandom_range(0, 24));
        else do_load(25'($urandom & $urandom));
      end else if (pick < 5) begin
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      end else if (pick < 10) begin
        int d;
        d = $urandom_range(1, 4);
        shot_row = 3'($urandom_range(0, 4)); shot_col = 3'($urandom_range(0, 4));
        shot_valid = 1'b1;
        @(posedge clk); #1 shot_valid = 1'b0;
        repeat (d - 1) begin @(posedge clk); #1; end
        do_load(25'($urandom & $urandom));
      end else begin
        if ($urandom_range(0, 9) < 8) shot($urandom_range(0, 4), $urandom_range(0, 4));
        else shot($urandom_range(0, 7), $urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
